// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between two byte requesters, the arbiter and a UART transmitter.
interface uart_tx_arbiter_if;
   logic       req0_valid;
   logic [7:0] req0_data;
   logic       req0_lock;
   logic       req0_ready;
   logic       req1_valid;
   logic [7:0] req1_data;
   logic       req1_lock;
   logic       req1_ready;
   logic [7:0] tx_data;
   logic       tx_start;
   logic       tx_busy;
   logic       owner;
   logic       locked;
   logic       tx_err;

   modport master (
      output req0_valid, req0_data, req0_lock, req1_valid, req1_data, req1_lock, tx_busy,
      input  req0_ready, req1_ready, tx_data, tx_start, owner, locked, tx_err
   );

   modport slave (
      input  req0_valid, req0_data, req0_lock, req1_valid, req1_data, req1_lock, tx_busy,
      output req0_ready, req1_ready, tx_data, tx_start, owner, locked, tx_err
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin arbiter feeding one UART transmitter, with
// multi-byte ownership lock and a start-to-busy timeout.
module uart_tx_arbiter (
   input  logic             clk,
   input  logic             rst_n,
   uart_tx_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;

   state_t     state;
   logic [2:0] timeout;
   logic [7:0] tx_data_q;
   logic       tx_start_q;
   logic       owner_q;
   logic       locked_q;
   logic       tx_err_q;

   logic       cand0, cand1, grant0, grant1, can_accept, own_valid, own_lock;

   always_comb begin
      cand0      = bus.req0_valid && (!locked_q || !owner_q);
      cand1      = bus.req1_valid && (!locked_q || owner_q);
      // On a tie the requester that did not send last wins.
      grant0     = cand0 && (!cand1 || owner_q);
      grant1     = cand1 && (!cand0 || !owner_q);
      can_accept = rst_n && (state == IDLE) && !bus.tx_busy;
      own_valid  = owner_q ? bus.req1_valid : bus.req0_valid;
      own_lock   = owner_q ? bus.req1_lock  : bus.req0_lock;
   end

   assign bus.req0_ready = can_accept && grant0;
   assign bus.req1_ready = can_accept && grant1;
   assign bus.tx_data    = tx_data_q;
   assign bus.tx_start   = tx_start_q;
   assign bus.owner      = owner_q;
   assign bus.locked     = locked_q;
   assign bus.tx_err     = tx_err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         timeout    <= '0;
         tx_data_q  <= '0;
         tx_start_q <= 1'b0;
         owner_q    <= 1'b1;
         locked_q   <= 1'b0;
         tx_err_q   <= 1'b0;
      end else begin
         tx_start_q <= 1'b0;
         tx_err_q   <= 1'b0;
         case (state)
            IDLE: begin
               if (can_accept && (grant0 || grant1)) begin
                  tx_data_q  <= grant1 ? bus.req1_data : bus.req0_data;
                  owner_q    <= grant1;
                  locked_q   <= grant1 ? bus.req1_lock : bus.req0_lock;
                  tx_start_q <= 1'b1;
                  timeout    <= '0;
                  state      <= WAIT_BUSY;
               end else if (locked_q && !own_valid && !own_lock) begin
                  // Owner walked away from its string: release the lock.
                  locked_q <= 1'b0;
               end
            end
            WAIT_BUSY: begin
               if (bus.tx_busy) begin
                  state <= WAIT_DONE;
               end else if (timeout == 3'd7) begin
                  tx_err_q <= 1'b1;
                  locked_q <= 1'b0;
                  state    <= IDLE;
               end else begin
                  timeout <= timeout + 3'd1;
               end
            end
            WAIT_DONE: begin
               if (!bus.tx_busy) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a simple transmitter busy model.
module tb_uart_tx_arbiter;
   typedef struct packed {
      logic [7:0] data;
      logic       src;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   uart_tx_arbiter_if bus ();
   uart_tx_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int   checks      = 0;
   int   failures    = 0;
   int   starts_seen = 0;
   exp_t exp_q[$];
   exp_t sb_item;

   logic model_en   = 1'b1;
   logic model_busy = 1'b0;
   logic force_busy = 1'b0;
   int   busy_len   = 3;
   assign bus.tx_busy = model_busy | force_busy;

   // Transmitter: busy rises the cycle after tx_start, lasts busy_len cycles.
   always begin
      @(negedge clk);
      if (model_en && rst_n && bus.tx_start) begin
         @(posedge clk);
         #1 model_busy = 1'b1;
         repeat (busy_len) @(posedge clk);
         #1 model_busy = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         checks++;
         if (bus.req0_ready && bus.req1_ready) begin
            failures++;
            $display("FAIL ready_onehot r0=%0b r1=%0b exp at most one high", bus.req0_ready, bus.req1_ready);
         end
         if (bus.tx_start) begin
            starts_seen++;
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL sb_unexpected tx_data=%h owner=%0b exp no start", bus.tx_data, bus.owner);
            end else begin
               sb_item = exp_q.pop_front();
               if (bus.tx_data !== sb_item.data || bus.owner !== sb_item.src) begin
                  failures++;
                  $display("FAIL sb_byte got data=%h owner=%0b exp data=%h owner=%0b",
                           bus.tx_data, bus.owner, sb_item.data, sb_item.src);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(output bit ok);
      int quiet = 0;
      ok = 1'b0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !bus.tx_busy && !bus.tx_start && !model_busy) quiet++;
         else quiet = 0;
         if (quiet >= 2) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic do_reset();
      step();
      rst_n = 1'b0;
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      bus.req0_lock  = 1'b0;
      bus.req1_lock  = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_reset();
      bus.req0_valid = 1'b1; bus.req0_data = 8'hAA;
      bus.req1_valid = 1'b1; bus.req1_data = 8'hBB;
      @(negedge clk);
      checks++;
      if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
         failures++; $display("FAIL reset_ready got r0=%0b r1=%0b exp 0 0", bus.req0_ready, bus.req1_ready);
      end
      checks++;
      if (bus.tx_start !== 1'b0 || bus.tx_err !== 1'b0) begin
         failures++; $display("FAIL reset_pulses got start=%0b err=%0b exp 0 0", bus.tx_start, bus.tx_err);
      end
      checks++;
      if (bus.tx_data !== 8'h00) begin
         failures++; $display("FAIL reset_tx_data got=%h exp=00", bus.tx_data);
      end
      checks++;
      if (bus.owner !== 1'b1 || bus.locked !== 1'b0) begin
         failures++; $display("FAIL reset_owner got owner=%0b locked=%0b exp 1 0", bus.owner, bus.locked);
      end
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      bit ok;
      step();
      bus.req0_data = 8'h48; bus.req0_lock = 1'b0; bus.req0_valid = 1'b1;
      exp_q.push_back('{data: 8'h48, src: 1'b0});
      @(negedge clk);
      checks++;
      if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
         failures++; $display("FAIL single_ready got r0=%0b r1=%0b exp 1 0", bus.req0_ready, bus.req1_ready);
      end
      step();
      bus.req0_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.tx_start !== 1'b1 || bus.tx_data !== 8'h48) begin
         failures++; $display("FAIL single_start got start=%0b data=%h exp 1 48", bus.tx_start, bus.tx_data);
      end
      wait_idle(ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL single_drain got busy exp idle"); end
      checks++;
      if (bus.owner !== 1'b0 || bus.locked !== 1'b0 || bus.tx_data !== 8'h48) begin
         failures++; $display("FAIL single_after got owner=%0b locked=%0b data=%h exp 0 0 48",
                              bus.owner, bus.locked, bus.tx_data);
      end
   endtask

   task automatic test_tie();
      bit         ok;
      int         n = 0;
      logic [2:0] srcs = '0;
      int         s0;
      do_reset();
      s0 = starts_seen;
      bus.req0_data = 8'h31; bus.req0_valid = 1'b1;
      bus.req1_data = 8'h32; bus.req1_valid = 1'b1;
      exp_q.push_back('{data: 8'h31, src: 1'b0});
      exp_q.push_back('{data: 8'h32, src: 1'b1});
      exp_q.push_back('{data: 8'h31, src: 1'b0});
      for (int c = 0; c < 100 && n < 3; c++) begin
         @(negedge clk);
         if (bus.req0_ready || bus.req1_ready) begin
            srcs[n] = bus.req1_ready;
            n++;
         end
      end
      step();
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      wait_idle(ok);
      checks++;
      if (n != 3 || srcs !== 3'b010) begin
         failures++; $display("FAIL tie_order got n=%0d srcs=%b exp 3 010", n, srcs);
      end
      checks++;
      if (!ok || starts_seen - s0 != 3) begin
         failures++; $display("FAIL tie_starts got %0d ok=%0b exp 3 1", starts_seen - s0, ok);
      end
   endtask

   task automatic test_lock();
      bit         ok;
      bit         early = 1'b0;
      bit         saw_lock = 1'b0;
      int         idx = 0;
      logic [3:0] srcs = '0;
      do_reset();
      bus.req0_data = 8'h48; bus.req0_lock = 1'b1; bus.req0_valid = 1'b1;
      bus.req1_data = 8'h41; bus.req1_lock = 1'b0; bus.req1_valid = 1'b1;
      exp_q.push_back('{data: 8'h48, src: 1'b0});
      exp_q.push_back('{data: 8'h69, src: 1'b0});
      exp_q.push_back('{data: 8'h0A, src: 1'b0});
      exp_q.push_back('{data: 8'h41, src: 1'b1});
      for (int c = 0; c < 300 && idx < 4; c++) begin
         @(negedge clk);
         if (idx >= 1 && idx < 3 && bus.locked === 1'b1) saw_lock = 1'b1;
         if (idx < 3 && bus.req1_ready) early = 1'b1;
         if (bus.req0_ready || bus.req1_ready) begin
            srcs[idx] = bus.req1_ready;
            idx++;
            step();
            case (idx)
               1: begin bus.req0_data = 8'h69; bus.req0_lock = 1'b1; end
               2: begin bus.req0_data = 8'h0A; bus.req0_lock = 1'b0; end
               3: bus.req0_valid = 1'b0;
               default: bus.req1_valid = 1'b0;
            endcase
         end
      end
      wait_idle(ok);
      checks++;
      if (idx != 4 || srcs !== 4'b1000) begin
         failures++; $display("FAIL lock_order got n=%0d srcs=%b exp 4 1000", idx, srcs);
      end
      checks++;
      if (early || !saw_lock) begin
         failures++; $display("FAIL lock_hold got early_r1=%0b saw_lock=%0b exp 0 1", early, saw_lock);
      end
      checks++;
      if (!ok || bus.locked !== 1'b0) begin
         failures++; $display("FAIL lock_release got ok=%0b locked=%0b exp 1 0", ok, bus.locked);
      end
   endtask

   task automatic test_timeout();
      bit ok;
      int first = 0;
      int pulses = 0;
      bit lk_hold = 1'b0;
      bit lk_clr = 1'b0;
      model_en = 1'b0;
      step();
      bus.req0_data = 8'h55; bus.req0_lock = 1'b1; bus.req0_valid = 1'b1;
      exp_q.push_back('{data: 8'h55, src: 1'b0});
      @(negedge clk);
      checks++;
      if (bus.req0_ready !== 1'b1) begin
         failures++; $display("FAIL tmo_accept got r0=%0b exp 1", bus.req0_ready);
      end
      step();
      bus.req0_valid = 1'b0;
      bus.req0_lock  = 1'b0;
      for (int j = 1; j <= 10; j++) begin
         @(negedge clk);
         if (bus.tx_err) begin
            pulses++;
            if (first == 0) first = j;
         end
         if (j == 1) lk_hold = bus.locked;
         if (j == 9) lk_clr = !bus.locked;
      end
      checks++;
      if (first != 9 || pulses != 1) begin
         failures++; $display("FAIL tmo_pulse got first=%0d pulses=%0d exp 9 1", first, pulses);
      end
      checks++;
      if (!lk_hold || !lk_clr) begin
         failures++; $display("FAIL tmo_locked got held=%0b cleared=%0b exp 1 1", lk_hold, lk_clr);
      end
      step();
      model_en = 1'b1;
      bus.req1_data = 8'h77; bus.req1_lock = 1'b0; bus.req1_valid = 1'b1;
      exp_q.push_back('{data: 8'h77, src: 1'b1});
      @(negedge clk);
      checks++;
      if (bus.req1_ready !== 1'b1) begin
         failures++; $display("FAIL tmo_idle got r1=%0b exp 1", bus.req1_ready);
      end
      step();
      bus.req1_valid = 1'b0;
      wait_idle(ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL tmo_drain got busy exp idle"); end
   endtask

   task automatic test_busy_idle();
      bit ok;
      bit any = 1'b0;
      force_busy = 1'b1;
      step();
      bus.req0_data = 8'h10; bus.req0_lock = 1'b0; bus.req0_valid = 1'b1;
      bus.req1_data = 8'h99; bus.req1_valid = 1'b1;
      repeat (4) begin
         @(negedge clk);
         if (bus.req0_ready || bus.req1_ready) any = 1'b1;
      end
      checks++;
      if (any) begin failures++; $display("FAIL busy_idle got ready=1 exp 0"); end
      step();
      force_busy = 1'b0;
      bus.req1_valid = 1'b0;
      exp_q.push_back('{data: 8'h10, src: 1'b0});
      @(negedge clk);
      checks++;
      if (bus.req0_ready !== 1'b1) begin
         failures++; $display("FAIL busy_release got r0=%0b exp 1", bus.req0_ready);
      end
      step();
      bus.req0_valid = 1'b0;
      wait_idle(ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL busy_drain got busy exp idle"); end
   endtask

   task automatic test_reset_mid();
      bit ok;
      bit got_busy = 1'b0;
      bit got_r1 = 1'b0;
      step();
      bus.req0_data = 8'h66; bus.req0_lock = 1'b1; bus.req0_valid = 1'b1;
      exp_q.push_back('{data: 8'h66, src: 1'b0});
      @(negedge clk);
      step();
      bus.req0_valid = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (bus.tx_busy) begin got_busy = 1'b1; break; end
      end
      checks++;
      if (!got_busy || bus.locked !== 1'b1) begin
         failures++; $display("FAIL rmid_setup got busy=%0b locked=%0b exp 1 1", got_busy, bus.locked);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (bus.tx_start !== 1'b0 || bus.locked !== 1'b0 || bus.owner !== 1'b1) begin
         failures++; $display("FAIL rmid_async got start=%0b locked=%0b owner=%0b exp 0 0 1",
                              bus.tx_start, bus.locked, bus.owner);
      end
      bus.req0_lock = 1'b0;
      for (int c = 0; c < 20 && model_busy; c++) @(posedge clk);
      step();
      rst_n = 1'b1;
      bus.req0_data = 8'h31; bus.req0_valid = 1'b1;
      bus.req1_data = 8'h32; bus.req1_lock = 1'b0; bus.req1_valid = 1'b1;
      exp_q.push_back('{data: 8'h31, src: 1'b0});
      exp_q.push_back('{data: 8'h32, src: 1'b1});
      @(negedge clk);
      checks++;
      if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
         failures++; $display("FAIL rmid_first got r0=%0b r1=%0b exp 1 0", bus.req0_ready, bus.req1_ready);
      end
      step();
      bus.req0_valid = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (bus.req1_ready) begin got_r1 = 1'b1; break; end
      end
      step();
      bus.req1_valid = 1'b0;
      wait_idle(ok);
      checks++;
      if (!got_r1 || !ok) begin
         failures++; $display("FAIL rmid_second got r1=%0b ok=%0b exp 1 1", got_r1, ok);
      end
   endtask

   task automatic test_abandon();
      bit ok;
      bit early = 1'b0;
      bit seen = 1'b0;
      bit ready_at_fall = 1'b0;
      int idle_locked = 0;
      step();
      bus.req1_data = 8'h21; bus.req1_lock = 1'b1; bus.req1_valid = 1'b1;
      exp_q.push_back('{data: 8'h21, src: 1'b1});
      @(negedge clk);
      checks++;
      if (bus.req1_ready !== 1'b1) begin
         failures++; $display("FAIL abandon_accept got r1=%0b exp 1", bus.req1_ready);
      end
      step();
      bus.req1_valid = 1'b0; bus.req1_lock = 1'b0;
      bus.req0_data = 8'h22; bus.req0_lock = 1'b0; bus.req0_valid = 1'b1;
      exp_q.push_back('{data: 8'h22, src: 1'b0});
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (bus.locked && bus.req0_ready) early = 1'b1;
         if (!bus.locked) begin
            ready_at_fall = bus.req0_ready;
            seen = 1'b1;
            break;
         end
         if (!bus.tx_busy && !bus.tx_start && !model_busy) idle_locked++;
      end
      checks++;
      if (!seen || early || !ready_at_fall) begin
         failures++; $display("FAIL abandon_grant got seen=%0b early=%0b ready=%0b exp 1 0 1",
                              seen, early, ready_at_fall);
      end
      checks++;
      if (idle_locked != 2) begin
         failures++; $display("FAIL abandon_timing got %0d locked idle cycles exp 2", idle_locked);
      end
      step();
      bus.req0_valid = 1'b0;
      wait_idle(ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL abandon_drain got busy exp idle"); end
   endtask

   initial begin
      bus.req0_valid = 1'b0; bus.req0_data = '0; bus.req0_lock = 1'b0;
      bus.req1_valid = 1'b0; bus.req1_data = '0; bus.req1_lock = 1'b0;
      test_reset();
      test_single();
      test_tie();
      test_lock();
      test_timeout();
      test_busy_idle();
      test_reset_mid();
      test_abandon();
      checks++;
      if (exp_q.size() != 0) begin
         failures++; $display("FAIL sb_leftover got %0d pending exp 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
